wptr_full_ctrl: RTL and testbench

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

---
 rtl/wptr_full_ctrl.sv | 94 +++++++++
 tb/tb_wptr_full_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/wptr_full_ctrl.sv
// Write-side controller for an asynchronous FIFO: binary/Gray write pointer, full and
// almost-full flags, fill level and sticky overflow. Define WPTR_OVF_COUNT_EN to add a
// saturating count of rejected writes; otherwise ovf_count is tied to zero.
module wptr_full_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              winc,
  input  logic              ovf_clr,
  input  logic [ADDR_W:0]   rptr_sync,
  output logic              wr_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  output logic [ADDR_W:0]   level,
  output logic [7:0]        ovf_count
);

  localparam logic [ADDR_W+1:0] AFULL_LVL = (ADDR_W+2)'(AFULL_THRESH);

  logic [ADDR_W:0] wbin;
  logic [ADDR_W:0] wbin_next;
  logic [ADDR_W:0] gray_next;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] rptr_full;
  logic [ADDR_W:0] level_next;
  logic            reject;

  always_comb begin
    wr_en      = winc & ~full & ~reset;
    reject     = winc & full & ~reset;
    wbin_next  = wbin + {{ADDR_W{1'b0}}, wr_en};
    gray_next  = (wbin_next >> 1) ^ wbin_next;
    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    rbin = '0;
    for (int unsigned i = 0; i <= ADDR_W; i++) begin
      rbin[i] = ^(rptr_sync >> i);
    end
    rptr_full  = rptr_sync ^ {2'b11, {(ADDR_W-1){1'b0}}};
    level_next = wbin_next - rbin;
  end

  assign waddr = wbin[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      wbin        <= '0;
      wptr        <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      level       <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr        <= gray_next;
      full        <= (gray_next == rptr_full);
      almost_full <= ({1'b0, level_next} >= AFULL_LVL);
      level       <= level_next;
      if (reject) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef WPTR_OVF_COUNT_EN
  logic [7:0] ovf_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_cnt <= '0;
    end else if (reject) begin
      // A clear in the same cycle as a rejection restarts the count at one.
      if (ovf_clr) begin
        ovf_cnt <= 8'd1;
      end else if (ovf_cnt != '1) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end
  end

  assign ovf_count = ovf_cnt;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl (ADDR_W=4, AFULL_THRESH=12); ovf_count expectations
// follow whether WPTR_OVF_COUNT_EN is defined for the build.
module tb_wptr_full_ctrl;

  localparam int ADDR_W = 4;
`ifdef WPTR_OVF_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              winc = 1'b1;
  logic              ovf_clr = 1'b0;
  logic [ADDR_W:0]   rptr_sync = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   wptr;
  logic              full;
  logic              almost_full;
  logic              overflow;
  logic [ADDR_W:0]   level;
  logic [7:0]        ovf_count;

  int errors = 0;
  int checks = 0;

  wptr_full_ctrl #(.ADDR_W(ADDR_W), .AFULL_THRESH(12)) dut (
    .clk(clk), .reset(reset), .winc(winc), .ovf_clr(ovf_clr), .rptr_sync(rptr_sync),
    .wr_en(wr_en), .waddr(waddr), .wptr(wptr), .full(full), .almost_full(almost_full),
    .overflow(overflow), .level(level), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  function automatic logic [ADDR_W:0] gray(input int unsigned b);
    logic [ADDR_W:0] v;
    v = b[ADDR_W:0];
    return (v >> 1) ^ v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; winc = 1'b1; ovf_clr = 1'b1; rptr_sync = '0;
    tick(); tick();
    checks++; if (wptr !== 5'd0) begin errors++; $display("FAIL reset_wptr: got %b expected 00000", wptr); end
    checks++; if (waddr !== 4'd0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", waddr); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if ({full, almost_full, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {full, almost_full, overflow}); end
    checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL reset_ovf_count: got %0d expected 0", ovf_count); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    reset = 1'b0; ovf_clr = 1'b0; winc = 1'b0;
    #1;
  endtask

  task automatic test_fill_to_full();
    winc = 1'b1; rptr_sync = '0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      checks++; if (wr_en !== 1'b1 || waddr !== 4'(k - 1)) begin errors++; $display("FAIL fill_write_%0d: got wr_en=%b waddr=%0d expected wr_en=1 waddr=%0d", k, wr_en, waddr, k - 1); end
      tick();
      if (k == 11) begin
        checks++; if (almost_full !== 1'b0 || level !== 5'd11) begin errors++; $display("FAIL afull_11: got af=%b level=%0d expected af=0 level=11", almost_full, level); end
      end
      if (k == 12) begin
        checks++; if (almost_full !== 1'b1 || level !== 5'd12) begin errors++; $display("FAIL afull_12: got af=%b level=%0d expected af=1 level=12", almost_full, level); end
      end
      if (k == 15) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_early: got %b expected 0", full); end
      end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_16: got %b expected 1", full); end
    checks++; if (wptr !== 5'b11000) begin errors++; $display("FAIL wptr_16: got %b expected 11000", wptr); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL level_16: got %0d expected 16", level); end
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL wr_en_when_full: got %b expected 0", wr_en); end
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_17: got %b expected 1", overflow); end
    checks++; if (wptr !== 5'b11000 || full !== 1'b1) begin errors++; $display("FAIL wptr_17: got wptr=%b full=%b expected 11000 1", wptr, full); end
    checks++; if (ovf_count !== (CNT_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL ovf_count_17: got %0d expected %0d", ovf_count, CNT_EN ? 1 : 0); end
  endtask

  task automatic test_drain();
    winc = 1'b0; ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL drain_clear: got ovf=%b full=%b expected 0 1", overflow, full); end
    rptr_sync = 5'b00110; winc = 1'b1;
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL drain_same_cycle_wr_en: got %b expected 0", wr_en); end
    tick();
    checks++; if (full !== 1'b0 || level !== 5'd12 || almost_full !== 1'b1) begin errors++; $display("FAIL drain_flags: got full=%b level=%0d af=%b expected 0 12 1", full, level, almost_full); end
    checks++; if (overflow !== 1'b1 || wptr !== 5'b11000) begin errors++; $display("FAIL drain_reject: got ovf=%b wptr=%b expected 1 11000", overflow, wptr); end
    #1;
    checks++; if (wr_en !== 1'b1 || waddr !== 4'd0) begin errors++; $display("FAIL drain_accept: got wr_en=%b waddr=%0d expected 1 0", wr_en, waddr); end
    tick();
    checks++; if (wptr !== 5'b11001 || level !== 5'd13 || full !== 1'b0) begin errors++; $display("FAIL drain_after_write: got wptr=%b level=%0d full=%b expected 11001 13 0", wptr, level, full); end
    winc = 1'b0;
  endtask

  task automatic test_overflow_counter();
    reset = 1'b1; tick(); reset = 1'b0;
    winc = 1'b1; rptr_sync = '0;
    for (int k = 0; k < 16; k++) tick();
    for (int k = 0; k < 3; k++) tick();
    checks++; if (ovf_count !== (CNT_EN ? 8'd3 : 8'd0) || overflow !== 1'b1) begin errors++; $display("FAIL ovf_count_3: got cnt=%0d ovf=%b expected %0d 1", ovf_count, overflow, CNT_EN ? 3 : 0); end
    ovf_clr = 1'b1;
    tick();
    checks++; if (ovf_count !== (CNT_EN ? 8'd1 : 8'd0) || overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_coincide: got cnt=%0d ovf=%b expected %0d 1", ovf_count, overflow, CNT_EN ? 1 : 0); end
    winc = 1'b0;
    tick();
    checks++; if (ovf_count !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr_only: got cnt=%0d ovf=%b expected 0 0", ovf_count, overflow); end
    ovf_clr = 1'b0; winc = 1'b1;
    for (int k = 0; k < 300; k++) tick();
    checks++; if (ovf_count !== (CNT_EN ? 8'd255 : 8'd0)) begin errors++; $display("FAIL ovf_count_sat: got %0d expected %0d", ovf_count, CNT_EN ? 255 : 0); end
    checks++; if (wptr !== 5'b11000 || level !== 5'd16) begin errors++; $display("FAIL ovf_hold_ptr: got wptr=%b level=%0d expected 11000 16", wptr, level); end
    winc = 1'b0; ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (ovf_count !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_final_clr: got cnt=%0d ovf=%b expected 0 0", ovf_count, overflow); end
  endtask

  task automatic test_wrap();
    logic fault;
    reset = 1'b1; tick(); reset = 1'b0;
    winc = 1'b1;
    fault = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      rptr_sync = (k >= 3) ? gray(k - 3) : 5'd0;
      tick();
      checks++;
      if (full !== 1'b0 || wptr !== gray(k) || level !== ((k < 3) ? 5'(k) : 5'd3) || almost_full !== 1'b0) begin
        errors++; fault = 1'b1;
        $display("FAIL wrap_%0d: got full=%b wptr=%b level=%0d af=%b expected 0 %b %0d 0", k, full, wptr, level, almost_full, gray(k), (k < 3) ? k : 3);
      end
    end
    checks++; if (wptr !== 5'd0 || waddr !== 4'd0) begin errors++; $display("FAIL wrap_end: got wptr=%b waddr=%0d expected 00000 0", wptr, waddr); end
    winc = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    reset = 1'b1; tick(); reset = 1'b0;
    rptr_sync = '0; winc = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    checks++; if (wptr !== 5'b00111 || level !== 5'd5) begin errors++; $display("FAIL mid_fill: got wptr=%b level=%0d expected 00111 5", wptr, level); end
    reset = 1'b1;
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL mid_reset_wr_en: got %b expected 0", wr_en); end
    tick();
    checks++; if (wptr !== 5'd0 || waddr !== 4'd0 || level !== 5'd0) begin errors++; $display("FAIL mid_reset_state: got wptr=%b waddr=%0d level=%0d expected 0 0 0", wptr, waddr, level); end
    reset = 1'b0;
    tick();
    checks++; if (wptr !== 5'b00001 || waddr !== 4'd1 || level !== 5'd1) begin errors++; $display("FAIL post_reset_write: got wptr=%b waddr=%0d level=%0d expected 00001 1 1", wptr, waddr, level); end
    winc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_to_full();
    test_drain();
    test_overflow_counter();
    test_wrap();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
